// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - two-requester round-robin arbiter feeding a UART serializer start/busy handshake.
// Optional START-state abort timer is built only with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t     state_q;
  logic       tx_start_q;
  logic [7:0] tx_data_q;
  logic [1:0] grant_q;
  logic [1:0] ready_q;
  logic       last_q;
  logic       pick1_d;
  logic       any_valid_d;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] tmo_cnt_q;
  logic          timeout_err_q;
`endif

  // last_q holds the index served most recently; a tie goes to the other one.
  always_comb begin
    any_valid_d = req0_valid | req1_valid;
    pick1_d     = 1'b0;
    if (req0_valid && req1_valid) begin
      pick1_d = ~last_q;
    end else begin
      pick1_d = req1_valid;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      grant_q    <= 2'b00;
      ready_q    <= 2'b00;
      last_q     <= 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      ready_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (!tx_busy && any_valid_d) begin
            tx_data_q  <= pick1_d ? req1_data : req0_data;
            grant_q    <= pick1_d ? 2'b10 : 2'b01;
            ready_q    <= pick1_d ? 2'b10 : 2'b01;
            tx_start_q <= 1'b1;
            state_q    <= START;
`ifdef UART_ARB_TIMEOUT_EN
            tmo_cnt_q  <= '0;
`endif
          end
        end
        START: begin
          if (tx_busy) begin
            tx_start_q <= 1'b0;
            state_q    <= WAIT_DONE;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            // Serializer never answered: give up and let the other requester in next.
            tx_start_q    <= 1'b0;
            timeout_err_q <= 1'b1;
            grant_q       <= 2'b00;
            last_q        <= grant_q[1];
            state_q       <= IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            grant_q <= 2'b00;
            last_q  <= grant_q[1];
            state_q <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          tx_start_q <= 1'b0;
          grant_q    <= 2'b00;
        end
      endcase
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign grant      = grant_q;
  assign req0_ready = ready_q[0];
  assign req1_ready = ready_q[1];

`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter.
module tb_uart_tx_arbiter;

  logic       clk;
  logic       wb_rst_i;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [1:0] grant;
  logic       timeout_err;

  typedef struct packed {
    logic [1:0] grant;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (wb_rst_i),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .grant      (grant),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every ready pulse must match the oldest expected grant.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!wb_rst_i) begin
        check("grant_onehot0", {31'd0, $onehot0(grant)}, 32'd1);
        check("ready_exclusive", {31'd0, req0_ready & req1_ready}, 32'd0);
        if (req0_ready || req1_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_ready: got ready=%b%b expected none", req1_ready, req0_ready);
          end else begin
            e = exp_q.pop_front();
            check("mon_grant", {30'd0, grant}, {30'd0, e.grant});
            check("mon_data", {24'd0, tx_data}, {24'd0, e.data});
            check("mon_tx_start", {31'd0, tx_start}, 32'd1);
            check("mon_ready", {30'd0, req1_ready, req0_ready}, {30'd0, e.grant});
          end
        end
      end
    end
  end

  task automatic push(input logic [1:0] g, input logic [7:0] d);
    exp_t e;
    e.grant = g;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  // Called at a negedge where tx_start is high: serializer accepts, runs, finishes.
  task automatic finish_from_start(input logic [7:0] d);
    tx_busy = 1'b1;
    @(negedge clk);
    check("start_dropped", {31'd0, tx_start}, 32'd0);
    check("data_held", {24'd0, tx_data}, {24'd0, d});
    @(negedge clk);
    check("data_held_wait", {24'd0, tx_data}, {24'd0, d});
    tx_busy = 1'b0;
    @(negedge clk);
    check("grant_idle", {30'd0, grant}, 32'd0);
  endtask

  task automatic xfer(input logic [7:0] d, input logic [1:0] drop);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (tx_start) seen = 1'b1;
    end
    check("start_seen", {31'd0, seen}, 32'd1);
    if (drop[0]) req0_valid = 1'b0;
    if (drop[1]) req1_valid = 1'b0;
    if (seen) finish_from_start(d);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
    check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    check({tag, "_grant"}, {30'd0, grant}, 32'd0);
    check({tag, "_ready0"}, {31'd0, req0_ready}, 32'd0);
    check({tag, "_ready1"}, {31'd0, req1_ready}, 32'd0);
    check({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    wb_rst_i    = 1'b1;
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    req0_data   = 8'h00;
    req1_data   = 8'h00;
    tx_busy     = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    wb_rst_i = 1'b0;

    // Single request, one-cycle latency, single ready pulse.
    req0_valid = 1'b1;
    req0_data  = 8'h3D;
    push(2'b01, 8'h3D);
    @(negedge clk);
    check("lat_tx_start", {31'd0, tx_start}, 32'd1);
    check("lat_ready0", {31'd0, req0_ready}, 32'd1);
    req0_valid = 1'b0;
    req0_data  = 8'hFF;
    @(negedge clk);
    check("ready_one_pulse", {31'd0, req0_ready}, 32'd0);
    check("start_held", {31'd0, tx_start}, 32'd1);
    check("data_ignores_req", {24'd0, tx_data}, 32'h3D);
    finish_from_start(8'h3D);

    // Tie right after reset goes to requester 0 first.
    wb_rst_i = 1'b1;
    @(negedge clk);
    wb_rst_i   = 1'b0;
    req0_valid = 1'b1;
    req0_data  = 8'h0F;
    req1_valid = 1'b1;
    req1_data  = 8'h3D;
    push(2'b01, 8'h0F);
    push(2'b10, 8'h3D);
    xfer(8'h0F, 2'b01);
    xfer(8'h3D, 2'b10);

    // Fairness with both valids held.
    req0_valid = 1'b1;
    req0_data  = 8'hA0;
    req1_valid = 1'b1;
    req1_data  = 8'hB1;
    push(2'b01, 8'hA0);
    push(2'b10, 8'hB1);
    push(2'b01, 8'hA0);
    push(2'b10, 8'hB1);
    xfer(8'hA0, 2'b00);
    xfer(8'hB1, 2'b00);
    xfer(8'hA0, 2'b00);
    xfer(8'hB1, 2'b11);

    // Busy hold in IDLE; single valid wins regardless of pointer.
    tx_busy    = 1'b1;
    req1_valid = 1'b1;
    req1_data  = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("busy_hold_no_start", {31'd0, tx_start}, 32'd0);
    end
    tx_busy = 1'b0;
    push(2'b10, 8'h5A);
    @(negedge clk);
    check("busy_release_start", {31'd0, tx_start}, 32'd1);
    req1_valid = 1'b0;
    finish_from_start(8'h5A);

    // Make requester 0 the last served so the post-reset tie proves the pointer reset.
    req0_valid = 1'b1;
    req0_data  = 8'hC3;
    push(2'b01, 8'hC3);
    xfer(8'hC3, 2'b01);

    // Reset during WAIT_DONE aborts the transfer.
    req1_valid = 1'b1;
    req1_data  = 8'h99;
    push(2'b10, 8'h99);
    @(negedge clk);
    check("abort_start", {31'd0, tx_start}, 32'd1);
    req1_valid = 1'b0;
    tx_busy    = 1'b1;
    @(negedge clk);
    wb_rst_i = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    wb_rst_i = 1'b0;
    tx_busy  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_start", {31'd0, tx_start}, 32'd0);
    end
    req0_valid = 1'b1;
    req0_data  = 8'h11;
    req1_valid = 1'b1;
    req1_data  = 8'h22;
    push(2'b01, 8'h11);
    push(2'b10, 8'h22);
    xfer(8'h11, 2'b01);
    xfer(8'h22, 2'b10);

`ifdef UART_ARB_TIMEOUT_EN
    begin
      int cnt;
      req0_valid = 1'b1;
      req0_data  = 8'hE1;
      push(2'b01, 8'hE1);
      @(negedge clk);
      req0_valid = 1'b0;
      cnt = 0;
      for (int i = 0; i < 40 && tx_start; i++) begin
        cnt++;
        @(negedge clk);
      end
      check("tmo_start_cycles", cnt, 32'd16);
      check("tmo_err_set", {31'd0, timeout_err}, 32'd1);
      check("tmo_grant_clear", {30'd0, grant}, 32'd0);
      repeat (3) @(negedge clk);
      check("tmo_err_sticky", {31'd0, timeout_err}, 32'd1);
      req1_valid = 1'b1;
      req1_data  = 8'h42;
      push(2'b10, 8'h42);
      xfer(8'h42, 2'b10);
      check("tmo_err_sticky2", {31'd0, timeout_err}, 32'd1);
    end
`else
    check("no_timeout_err", {31'd0, timeout_err}, 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
